// File: rtl/ycbcr_arbiter.sv
// Two-requester, line-atomic arbiter that feeds a shared RGB->YCbCr converter into a 2-deep output FIFO.
// Optional per-channel line counters are enabled by defining YCBCR_ARB_STATS_EN.
module ycbcr_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [23:0] s0_rgb,
  input  logic        s0_eol,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [23:0] s1_rgb,
  input  logic        s1_eol,
  output logic [7:0]  cv_r_data,
  output logic [7:0]  cv_g_data,
  output logic [7:0]  cv_b_data,
  input  logic [7:0]  cv_y_data,
  input  logic [7:0]  cv_cb_data,
  input  logic [7:0]  cv_cr_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_ycbcr,
  output logic        m_ch,
  output logic        m_eol
`ifdef YCBCR_ARB_STATS_EN
  ,
  output logic [15:0] line_cnt0,
  output logic [15:0] line_cnt1
`endif
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_ch_q, last_ch_d;
  logic [25:0] fifo_q [2];
  logic [25:0] fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        space;
  logic        acc0, acc1;
  logic        push, pop;
  logic [23:0] sel_rgb;
  logic [25:0] push_data;
  logic [25:0] head;

  // Handshake and converter steering
  always_comb begin
    space    = (count_q != 2'd2);
    s0_ready = (state_q == StGnt0) && space;
    s1_ready = (state_q == StGnt1) && space;
    acc0     = s0_valid && s0_ready;
    acc1     = s1_valid && s1_ready;
    push     = acc0 || acc1;
    pop      = m_valid && m_ready;

    sel_rgb = 24'h000000;
    unique case (state_q)
      StGnt0:  sel_rgb = s0_rgb;
      StGnt1:  sel_rgb = s1_rgb;
      default: sel_rgb = 24'h000000;
    endcase
    cv_r_data = sel_rgb[23:16];
    cv_g_data = sel_rgb[15:8];
    cv_b_data = sel_rgb[7:0];

    push_data = {(state_q == StGnt1), (acc0 ? s0_eol : s1_eol),
                 cv_y_data, cv_cb_data, cv_cr_data};
  end

  // Grant FSM: a grant is only released on an accepted end-of-line beat
  always_comb begin
    state_d   = state_q;
    last_ch_d = last_ch_q;
    unique case (state_q)
      StIdle: begin
        if (s0_valid && s1_valid) begin
          state_d = last_ch_q ? StGnt0 : StGnt1;
        end else if (s0_valid) begin
          state_d = StGnt0;
        end else if (s1_valid) begin
          state_d = StGnt1;
        end
      end
      StGnt0: begin
        if (acc0 && s0_eol) begin
          last_ch_d = 1'b0;
          state_d   = s1_valid ? StGnt1 : StIdle;
        end
      end
      StGnt1: begin
        if (acc1 && s1_eol) begin
          last_ch_d = 1'b1;
          state_d   = s0_valid ? StGnt0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output FIFO
  always_comb begin
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    if (push) begin
      fifo_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    head    = fifo_q[rd_ptr_q];
    m_valid = (count_q != 2'd0);
    m_ycbcr = m_valid ? head[23:0] : 24'h000000;
    m_ch    = m_valid && head[25];
    m_eol   = m_valid && head[24];
  end

`ifdef YCBCR_ARB_STATS_EN
  logic [15:0] line_cnt0_q, line_cnt0_d;
  logic [15:0] line_cnt1_q, line_cnt1_d;

  always_comb begin
    line_cnt0_d = line_cnt0_q + {15'd0, (acc0 && s0_eol)};
    line_cnt1_d = line_cnt1_q + {15'd0, (acc1 && s1_eol)};
    line_cnt0   = line_cnt0_q;
    line_cnt1   = line_cnt1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt0_q <= 16'd0;
      line_cnt1_q <= 16'd0;
    end else begin
      line_cnt0_q <= line_cnt0_d;
      line_cnt1_q <= line_cnt1_d;
    end
  end
`endif

  // last_ch resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_ch_q <= 1'b1;
      fifo_q[0] <= 26'd0;
      fifo_q[1] <= 26'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      last_ch_q <= last_ch_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_ycbcr_arbiter.sv
// Directed bench for ycbcr_arbiter with a BT.601-style integer converter model on the cv_* loop.
module tb_ycbcr_arbiter;

  logic        clk;
  logic        rst;
  logic        s0_valid, s0_ready, s0_eol;
  logic [23:0] s0_rgb;
  logic        s1_valid, s1_ready, s1_eol;
  logic [23:0] s1_rgb;
  logic [7:0]  cv_r_data, cv_g_data, cv_b_data;
  logic [7:0]  cv_y_data, cv_cb_data, cv_cr_data;
  logic        m_valid, m_ready, m_ch, m_eol;
  logic [23:0] m_ycbcr;
`ifdef YCBCR_ARB_STATS_EN
  logic [15:0] line_cnt0, line_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  ycbcr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .s0_valid   (s0_valid),
    .s0_ready   (s0_ready),
    .s0_rgb     (s0_rgb),
    .s0_eol     (s0_eol),
    .s1_valid   (s1_valid),
    .s1_ready   (s1_ready),
    .s1_rgb     (s1_rgb),
    .s1_eol     (s1_eol),
    .cv_r_data  (cv_r_data),
    .cv_g_data  (cv_g_data),
    .cv_b_data  (cv_b_data),
    .cv_y_data  (cv_y_data),
    .cv_cb_data (cv_cb_data),
    .cv_cr_data (cv_cr_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_ycbcr    (m_ycbcr),
    .m_ch       (m_ch),
    .m_eol      (m_eol)
`ifdef YCBCR_ARB_STATS_EN
    ,
    .line_cnt0  (line_cnt0),
    .line_cnt1  (line_cnt1)
`endif
  );

  function automatic logic [23:0] conv(input logic [23:0] rgb);
    int r, g, b, y, cb, cr;
    r  = int'(rgb[23:16]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[7:0]);
    y  = ((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16;
    cb = ((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128;
    cr = ((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128;
    return {y[7:0], cb[7:0], cr[7:0]};
  endfunction

  always_comb begin
    {cv_y_data, cv_cb_data, cv_cr_data} = conv({cv_r_data, cv_g_data, cv_b_data});
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    s0_eol   = 1'b0;
    s1_eol   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [23:0] p [4];
    logic [23:0] r0, r1;
    logic        a0, a1;
    int          i0, i1;

    s0_rgb  = 24'h0;
    s1_rgb  = 24'h0;
    m_ready = 1'b1;
    do_reset();

    // Reset state
    chk("rst_s0_ready", s0_ready, 1'b0);
    chk("rst_s1_ready", s1_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_ycbcr", m_ycbcr, 24'h0);
    chk("rst_m_ch", m_ch, 1'b0);
    chk("rst_m_eol", m_eol, 1'b0);
    chk("rst_cv", {cv_r_data, cv_g_data, cv_b_data}, 24'h0);

    // Single requester, 4-pixel line
    p[0] = 24'h102030; p[1] = 24'h405060; p[2] = 24'h708090; p[3] = 24'hA0B0C0;
    s0_valid = 1'b1; s0_rgb = p[0]; s0_eol = 1'b0;
    #1;
    chk("t1_bubble_ready", s0_ready, 1'b0);
    chk("t1_idle_cv", {cv_r_data, cv_g_data, cv_b_data}, 24'h0);
    tick();
    chk("t1_gnt_ready", s0_ready, 1'b1);
    chk("t1_s1_ready", s1_ready, 1'b0);
    chk("t1_cv", {cv_r_data, cv_g_data, cv_b_data}, p[0]);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t1_m_valid", m_valid, 1'b1);
      chk("t1_m_ycbcr", m_ycbcr, conv(p[k-1]));
      chk("t1_m_ch", m_ch, 1'b0);
      chk("t1_m_eol", m_eol, 1'b0);
      s0_rgb = p[k];
      s0_eol = (k == 3);
    end
    #1;
    chk("t1_eol_ready", s0_ready, 1'b1);
    tick();
    chk("t1_last_ycbcr", m_ycbcr, conv(p[3]));
    chk("t1_last_eol", m_eol, 1'b1);
    chk("t1_idle_s0_ready", s0_ready, 1'b0);
    chk("t1_idle_s1_ready", s1_ready, 1'b0);
    s0_valid = 1'b0;
    tick();
    chk("t1_drained", m_valid, 1'b0);

    // Both requesters, 3-pixel lines: ch0, ch1, ch0 back to back
    do_reset();
    i0 = 0; i1 = 0;
    s0_valid = 1'b1; s1_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      s0_rgb = {8'h10 + i0[7:0], 8'h20, 8'h30};
      s0_eol = (i0 % 3 == 2);
      s1_rgb = {8'h40, 8'h50 + i1[7:0], 8'h60};
      s1_eol = (i1 % 3 == 2);
      #1;
      chk("t2_s0_ready", s0_ready, ((c >= 1 && c <= 3) || c >= 7));
      chk("t2_s1_ready", s1_ready, (c >= 4 && c <= 6));
      a0 = s0_ready; a1 = s1_ready;
      r0 = s0_rgb;   r1 = s1_rgb;
      tick();
      if (a0) begin
        chk("t2_ch0_m_ch", m_ch, 1'b0);
        chk("t2_ch0_ycbcr", m_ycbcr, conv(r0));
        chk("t2_ch0_eol", m_eol, (i0 % 3 == 2));
        i0++;
      end else if (a1) begin
        chk("t2_ch1_m_ch", m_ch, 1'b1);
        chk("t2_ch1_ycbcr", m_ycbcr, conv(r1));
        chk("t2_ch1_eol", m_eol, (i1 % 3 == 2));
        i1++;
      end else begin
        chk("t2_bubble_m_valid", m_valid, 1'b0);
      end
    end
    chk("t2_ch0_beats", i0, 6);
    chk("t2_ch1_beats", i1, 3);
`ifdef YCBCR_ARB_STATS_EN
    chk("t2_line_cnt0", line_cnt0, 16'd2);
    chk("t2_line_cnt1", line_cnt1, 16'd1);
`endif

    // Pure red through ch1 against a hand-computed converter result
    do_reset();
    s1_valid = 1'b1; s1_rgb = 24'hFF0000; s1_eol = 1'b1;
    tick();
    chk("t3_cv", {cv_r_data, cv_g_data, cv_b_data}, 24'hFF0000);
    chk("t3_s1_ready", s1_ready, 1'b1);
    tick();
    s1_valid = 1'b0;
    chk("t3_m_valid", m_valid, 1'b1);
    chk("t3_m_ycbcr", m_ycbcr, 24'h525AF0);
    chk("t3_m_ch", m_ch, 1'b1);
    chk("t3_m_eol", m_eol, 1'b1);

    // Backpressure: FIFO fills at 2, output holds, then drains in order
    do_reset();
    p[0] = 24'h123456; p[1] = 24'h654321; p[2] = 24'h0FF00F; p[3] = 24'h80C020;
    m_ready = 1'b0;
    s0_valid = 1'b1; s0_rgb = p[0]; s0_eol = 1'b0;
    tick();
    tick();
    chk("t4_first_ycbcr", m_ycbcr, conv(p[0]));
    chk("t4_ready_cnt1", s0_ready, 1'b1);
    s0_rgb = p[1];
    tick();
    chk("t4_ready_full", s0_ready, 1'b0);
    chk("t4_hold_ycbcr", m_ycbcr, conv(p[0]));
    s0_rgb = p[2];
    tick();
    chk("t4_still_full", s0_ready, 1'b0);
    chk("t4_stable_valid", m_valid, 1'b1);
    chk("t4_stable_ycbcr", m_ycbcr, conv(p[0]));
    chk("t4_stable_ch", m_ch, 1'b0);
    m_ready = 1'b1;
    tick();
    chk("t4_drain1", m_ycbcr, conv(p[1]));
    chk("t4_ready_again", s0_ready, 1'b1);
    tick();
    chk("t4_drain2", m_ycbcr, conv(p[2]));
    s0_valid = 1'b0;
    tick();
    chk("t4_empty", m_valid, 1'b0);
    chk("t4_midline_hold", s0_ready, 1'b1);

    // Reset mid-line with FIFO full
    m_ready = 1'b0;
    s0_valid = 1'b1; s0_rgb = p[3];
    tick();
    tick();
    chk("t5_full_valid", m_valid, 1'b1);
    chk("t5_full_ready", s0_ready, 1'b0);
    rst = 1'b1;
    tick();
    chk("t5_rst_m_valid", m_valid, 1'b0);
    chk("t5_rst_s0_ready", s0_ready, 1'b0);
    chk("t5_rst_s1_ready", s1_ready, 1'b0);
    chk("t5_rst_ycbcr", m_ycbcr, 24'h0);
    rst = 1'b0; m_ready = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1;
    tick();
    chk("t5_tie_s0_ready", s0_ready, 1'b1);
    chk("t5_tie_s1_ready", s1_ready, 1'b0);
    chk("t5_no_stale", m_valid, 1'b0);
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
